// File: rtl/trig_admit_pkg.sv
// Shared types and helpers for the trigger admission controller.
//   state_t  : admission FSM encoding (IDLE / ARMED / HOLDOFF)
//   SRC_W    : width of a source index (up to 8 sources)
//   CREDIT_W : width of the event-buffer credit count (up to 15 buffers)
//   popcount : number of set bits in an 8-bit vector
package trig_admit_pkg;

  localparam int SRC_W    = 3;
  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/trig_admit_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per source
//   ptr         : index where the search starts (highest priority)
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : index of the granted source
//   grant_valid : at least one request was present
module rr_arbiter
  import trig_admit_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [SRC_W:0] pos;

  // Walk the sources starting at ptr, wrapping at NREQ; the first
  // requesting source seen wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (SRC_W+1)'(i);
      if (pos >= (SRC_W+1)'(NREQ)) begin
        pos = pos - (SRC_W+1)'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_valid && (pos == (SRC_W+1)'(j)) && req[j]) begin
          grant_valid = 1'b1;
          grant[j]    = 1'b1;
          grant_idx   = SRC_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/trig_admit_ctrl.sv
// Trigger admission controller (aclk domain).
// Arbitrates trigger requests round-robin, enforces a holdoff deadtime after
// every admit and event-buffer credits, and emits one registered
// trig_time_valid_o pulse per admitted event with its running event number.
//
// Ports:
//   aclk_i / aclk_rst_i   clock, async active-high reset
//   run_rst_i             sync reset, same effect as aclk_rst_i
//   run_en_i              acceptance enable
//   mask_i                per-source disable
//   req_valid_i/req_time_i/req_ready_o  request handshake per source
//   holdoff_i             deadtime in cycles, sampled at admit
//   buf_done_i            credit return pulse
//   trig_time_o/trig_time_valid_o/trig_src_o/event_no_o  admitted event
//   credits_o, busy_o, drop_count_o, credit_err_o        status
//   dbg_state_o           current FSM state
//
// Handshake: req_ready_o[k] is a combinational consume strobe. Whenever
// req_valid_i[k] and req_ready_o[k] are both high in a cycle, request k is
// consumed -- either admitted (it is the grant) or discarded. A valid request
// with ready low stays pending and must be held by the source.
module trig_admit_ctrl
  import trig_admit_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int NBUF   = 4,
  parameter int TIME_W = 16
) (
  input  logic                   aclk_i,
  input  logic                   aclk_rst_i,
  input  logic                   run_rst_i,
  input  logic                   run_en_i,
  input  logic [NREQ-1:0]        mask_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*TIME_W-1:0] req_time_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [15:0]            holdoff_i,
  input  logic                   buf_done_i,
  output logic [TIME_W-1:0]      trig_time_o,
  output logic                   trig_time_valid_o,
  output logic [SRC_W-1:0]       trig_src_o,
  output logic [15:0]            event_no_o,
  output logic [CREDIT_W-1:0]    credits_o,
  output logic                   busy_o,
  output logic [15:0]            drop_count_o,
  output logic                   credit_err_o,
  output state_t                 dbg_state_o
);

  state_t              state_q, state_d;
  logic [15:0]         hold_cnt_q, hold_cnt_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]         event_cnt_q, event_cnt_d;
  logic [15:0]         drop_q, drop_d;
  logic                err_q, err_d;
  logic                busy_d;
  logic                valid_d;
  logic [TIME_W-1:0]   time_d;
  logic [SRC_W-1:0]    src_d;
  logic [15:0]         event_no_d;

  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     masked_drop;
  logic [NREQ-1:0]     reject_set;
  logic [NREQ-1:0]     grant;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                can_admit;
  logic                admit;
  logic                credit_full;
  logic                credit_ret;
  logic                credit_ovf;
  logic [16:0]         drop_sum;

  assign elig        = req_valid_i & ~mask_i;
  assign masked_drop = req_valid_i & mask_i;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req         (elig),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign can_admit  = (state_q == ARMED) && (credits_q != '0);
  assign admit      = can_admit && grant_valid;
  assign reject_set = can_admit ? '0 : elig;

  assign req_ready_o = masked_drop | reject_set | (admit ? grant : '0);

  // A return while the pool is full is only legal if an admit takes a
  // credit in the same cycle; otherwise it is ignored and flagged.
  assign credit_full = (credits_q == CREDIT_W'(NBUF));
  assign credit_ovf  = buf_done_i && credit_full && !admit;
  assign credit_ret  = buf_done_i && !credit_ovf;

  assign drop_sum = {1'b0, drop_q} + 17'(popcount(8'(reject_set)));

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    credits_d   = credits_q - CREDIT_W'(admit) + CREDIT_W'(credit_ret);
    rr_ptr_d    = rr_ptr_q;
    event_cnt_d = event_cnt_q;
    drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    err_d       = err_q | credit_ovf;
    valid_d     = admit;
    time_d      = trig_time_o;
    src_d       = trig_src_o;
    event_no_d  = event_no_o;

    unique case (state_q)
      IDLE: begin
        if (run_en_i) state_d = ARMED;
      end
      ARMED: begin
        if (!run_en_i) begin
          state_d = IDLE;
        end else if (admit && (holdoff_i != 16'd0)) begin
          state_d    = HOLDOFF;
          hold_cnt_d = holdoff_i;
        end
      end
      HOLDOFF: begin
        if (!run_en_i) begin
          state_d = IDLE;
        end else if (hold_cnt_q <= 16'd1) begin
          state_d = ARMED;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (admit) begin
      rr_ptr_d    = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      time_d      = req_time_i[grant_idx*TIME_W +: TIME_W];
      src_d       = grant_idx;
      event_no_d  = event_cnt_q;
      event_cnt_d = event_cnt_q + 16'd1;
    end

    // Run reset overrides everything computed above, including any
    // same-cycle admit or credit return.
    if (run_rst_i) begin
      state_d     = IDLE;
      hold_cnt_d  = '0;
      credits_d   = CREDIT_W'(NBUF);
      rr_ptr_d    = '0;
      event_cnt_d = '0;
      drop_d      = '0;
      err_d       = 1'b0;
      valid_d     = 1'b0;
      time_d      = '0;
      src_d       = '0;
      event_no_d  = '0;
    end

    busy_d = (state_d != ARMED) || (credits_d == '0);
  end

  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      state_q           <= IDLE;
      hold_cnt_q        <= '0;
      credits_q         <= CREDIT_W'(NBUF);
      rr_ptr_q          <= '0;
      event_cnt_q       <= '0;
      drop_q            <= '0;
      err_q             <= 1'b0;
      busy_o            <= 1'b1;
      trig_time_valid_o <= 1'b0;
      trig_time_o       <= '0;
      trig_src_o        <= '0;
      event_no_o        <= '0;
    end else begin
      state_q           <= state_d;
      hold_cnt_q        <= hold_cnt_d;
      credits_q         <= credits_d;
      rr_ptr_q          <= rr_ptr_d;
      event_cnt_q       <= event_cnt_d;
      drop_q            <= drop_d;
      err_q             <= err_d;
      busy_o            <= busy_d;
      trig_time_valid_o <= valid_d;
      trig_time_o       <= time_d;
      trig_src_o        <= src_d;
      event_no_o        <= event_no_d;
    end
  end

  assign credits_o    = credits_q;
  assign drop_count_o = drop_q;
  assign credit_err_o = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_trig_admit_ctrl.sv
module tb_trig_admit_ctrl;
  import trig_admit_pkg::*;

  localparam int NREQ   = 3;
  localparam int NBUF   = 4;
  localparam int TIME_W = 16;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aclk_rst = 1'b1;
  always #5 aclk = ~aclk;

  logic                   run_rst;
  logic                   run_en;
  logic [NREQ-1:0]        mask;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TIME_W-1:0] req_time;
  logic [NREQ-1:0]        req_ready;
  logic [15:0]            holdoff;
  logic                   buf_done;
  logic [TIME_W-1:0]      trig_time;
  logic                   trig_valid;
  logic [SRC_W-1:0]       trig_src;
  logic [15:0]            event_no;
  logic [CREDIT_W-1:0]    credits;
  logic                   busy;
  logic [15:0]            drop_count;
  logic                   credit_err;
  state_t                 dut_state;

  trig_admit_ctrl #(.NREQ(NREQ), .NBUF(NBUF), .TIME_W(TIME_W)) dut (
    .aclk_i            (aclk),
    .aclk_rst_i        (aclk_rst),
    .run_rst_i         (run_rst),
    .run_en_i          (run_en),
    .mask_i            (mask),
    .req_valid_i       (req_valid),
    .req_time_i        (req_time),
    .req_ready_o       (req_ready),
    .holdoff_i         (holdoff),
    .buf_done_i        (buf_done),
    .trig_time_o       (trig_time),
    .trig_time_valid_o (trig_valid),
    .trig_src_o        (trig_src),
    .event_no_o        (event_no),
    .credits_o         (credits),
    .busy_o            (busy),
    .drop_count_o      (drop_count),
    .credit_err_o      (credit_err),
    .dbg_state_o       (dut_state)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [SRC_W-1:0] exp_src [4];
  int               n_valid;

  initial begin
    run_rst   = 1'b0;
    run_en    = 1'b0;
    mask      = '0;
    req_valid = '0;
    req_time  = '0;
    holdoff   = '0;
    buf_done  = 1'b0;

    // ---- reset values ----
    tick();
    tick();
    check("rst_valid",   32'(trig_valid), 32'd0);
    check("rst_time",    32'(trig_time),  32'd0);
    check("rst_src",     32'(trig_src),   32'd0);
    check("rst_event",   32'(event_no),   32'd0);
    check("rst_drop",    32'(drop_count), 32'd0);
    check("rst_err",     32'(credit_err), 32'd0);
    check("rst_busy",    32'(busy),       32'd1);
    check("rst_credits", 32'(credits),    32'd4);
    check("rst_state",   32'(dut_state),  32'(IDLE));

    // ---- single admit from source 1 ----
    aclk_rst = 1'b0;
    run_en   = 1'b1;
    tick();
    check("arm_state", 32'(dut_state), 32'(ARMED));
    check("arm_busy",  32'(busy),      32'd0);
    req_valid = 3'b010;
    req_time  = {16'h0000, 16'h1234, 16'h0000};
    settle();
    check("t1_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    check("t1_valid",   32'(trig_valid), 32'd1);
    check("t1_time",    32'(trig_time),  32'h1234);
    check("t1_src",     32'(trig_src),   32'd1);
    check("t1_event",   32'(event_no),   32'd0);
    check("t1_credits", 32'(credits),    32'd3);
    tick();
    check("t1_pulse_end", 32'(trig_valid), 32'd0);
    check("t1_time_hold", 32'(trig_time),  32'h1234);

    // ---- run reset, then round-robin over all three sources ----
    run_rst = 1'b1;
    tick();
    run_rst = 1'b0;
    tick();
    check("t2_state", 32'(dut_state), 32'(ARMED));
    exp_src[0] = 3'd0;
    exp_src[1] = 3'd1;
    exp_src[2] = 3'd2;
    exp_src[3] = 3'd0;
    req_valid = 3'b111;
    req_time  = {16'h0300, 16'h0200, 16'h0100};
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t2_ready", 32'(req_ready), 32'(1 << exp_src[i]));
      tick();
      check("t2_valid", 32'(trig_valid), 32'd1);
      check("t2_src",   32'(trig_src),   32'(exp_src[i]));
      check("t2_time",  32'(trig_time),  32'h100 * (32'(exp_src[i]) + 1));
      check("t2_event", 32'(event_no),   32'(i));
    end
    check("t2_credits0", 32'(credits), 32'd0);
    check("t2_busy",     32'(busy),    32'd1);
    settle();
    check("t2_drop_ready", 32'(req_ready), 32'b111);
    tick();
    req_valid = '0;
    check("t2_drop_count", 32'(drop_count), 32'd3);
    check("t2_no_admit",   32'(trig_valid), 32'd0);

    // ---- credit return races a request, then overflow ----
    buf_done  = 1'b1;
    req_valid = 3'b100;
    req_time  = {16'h0777, 16'h0000, 16'h0000};
    settle();
    check("t4_drop_ready", 32'(req_ready), 32'b100);
    tick();
    buf_done = 1'b0;
    check("t4_credits1", 32'(credits),    32'd1);
    check("t4_drop",     32'(drop_count), 32'd4);
    check("t4_no_admit", 32'(trig_valid), 32'd0);
    settle();
    check("t4_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    check("t4_valid",    32'(trig_valid), 32'd1);
    check("t4_src",      32'(trig_src),   32'd2);
    check("t4_time",     32'(trig_time),  32'h0777);
    check("t4_event",    32'(event_no),   32'd4);
    check("t4_credits0", 32'(credits),    32'd0);
    buf_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t4_credits4", 32'(credits),    32'd4);
    check("t4_err0",     32'(credit_err), 32'd0);
    tick();
    buf_done = 1'b0;
    check("t4_err1",    32'(credit_err), 32'd1);
    check("t4_cred_ov", 32'(credits),    32'd4);
    tick();
    check("t4_err_sticky", 32'(credit_err), 32'd1);

    // ---- masked source ----
    mask      = 3'b010;
    req_valid = 3'b010;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t5_ready", 32'(req_ready), 32'b010);
      tick();
      check("t5_no_admit", 32'(trig_valid), 32'd0);
    end
    check("t5_drop", 32'(drop_count), 32'd4);
    mask      = '0;
    req_valid = '0;

    // ---- holdoff 5: admits six cycles apart ----
    holdoff   = 16'd5;
    req_valid = 3'b001;
    req_time  = {16'h0000, 16'h0000, 16'h0ABC};
    for (int k = 0; k < 13; k++) begin
      tick();
      check("t3_valid", 32'(trig_valid), (k % 6 == 0) ? 32'd1 : 32'd0);
    end
    req_valid = '0;
    holdoff   = '0;
    check("t3_event",   32'(event_no),   32'd7);
    check("t3_drop",    32'(drop_count), 32'd14);
    check("t3_credits", 32'(credits),    32'd1);
    check("t3_state",   32'(dut_state),  32'(HOLDOFF));
    check("t3_busy",    32'(busy),       32'd1);

    // ---- run reset mid-holdoff ----
    run_rst = 1'b1;
    tick();
    run_rst = 1'b0;
    check("rr_state",   32'(dut_state),  32'(IDLE));
    check("rr_event",   32'(event_no),   32'd0);
    check("rr_credits", 32'(credits),    32'd4);
    check("rr_drop",    32'(drop_count), 32'd0);
    check("rr_err",     32'(credit_err), 32'd0);
    check("rr_busy",    32'(busy),       32'd1);
    check("rr_time",    32'(trig_time),  32'd0);

    // ---- run_en low returns to IDLE and drops requests ----
    tick();
    check("en_armed", 32'(dut_state), 32'(ARMED));
    run_en = 1'b0;
    tick();
    check("en_idle", 32'(dut_state), 32'(IDLE));
    check("en_busy", 32'(busy),      32'd1);
    req_valid = 3'b001;
    settle();
    check("en_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    check("en_drop",     32'(drop_count), 32'd1);
    check("en_no_admit", 32'(trig_valid), 32'd0);

    // ---- event number wrap over 65536 admits ----
    run_en = 1'b1;
    tick();
    req_valid = 3'b001;
    buf_done  = 1'b1;
    n_valid   = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (trig_valid) n_valid++;
      if (i == 65535) check("wrap_last", 32'(event_no), 32'hFFFF);
    end
    check("wrap_count", 32'(n_valid), 32'd65536);
    tick();
    check("wrap_zero",    32'(event_no),   32'h0000);
    check("wrap_valid",   32'(trig_valid), 32'd1);
    check("wrap_credits", 32'(credits),    32'd4);
    check("wrap_err",     32'(credit_err), 32'd0);

    // ---- async reset asserted between edges ----
    holdoff = 16'd3;
    tick();
    req_valid = '0;
    buf_done  = 1'b0;
    check("ar_holdoff", 32'(dut_state), 32'(HOLDOFF));
    #2;
    aclk_rst = 1'b1;
    #1;
    check("ar_state",   32'(dut_state),  32'(IDLE));
    check("ar_event",   32'(event_no),   32'd0);
    check("ar_credits", 32'(credits),    32'd4);
    check("ar_drop",    32'(drop_count), 32'd0);
    check("ar_valid",   32'(trig_valid), 32'd0);
    check("ar_busy",    32'(busy),       32'd1);
    check("ar_time",    32'(trig_time),  32'd0);
    check("ar_src",     32'(trig_src),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
